mdu_e: RTL

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. Sits directly downstream of the D→E pipeline register and consumes its `MDUOp_E` field plus the forwarded E-stage operands. Holds the architectural HI/LO registers and models multi-cycle `mult`/`div` latency with a `busy` flag. Exposes `start`/`busy` to the hazard unit, and the mfhi/mflo result to the E-stage writeback mux.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_calc.sv | 77 +++++++
 rtl/mdu_e.sv | 101 ++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encoding carried in MDUOp_E and default latencies.
// Imported by the MDU, the D->E register consumer and the hazard unit.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;

   // True for the four multi-cycle operations that occupy the unit.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   function automatic logic is_mult(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: produces the HI/LO result of mult/multu/div/divu,
// including MIPS-style divide-by-zero and signed-overflow results.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_res,
   output logic [31:0] lo_res
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic               div_zero;
   logic               div_ovf;

   assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u   = {32'd0, a} * {32'd0, b};
   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // Quotient truncates toward zero and remainder takes the dividend's sign.
   // Only meaningful when neither special case applies; those are overridden below.
   always_comb begin
      quot_s = 32'sd0;
      rem_s  = 32'sd0;
      if (!div_zero && !div_ovf) begin
         quot_s = $signed(a) / $signed(b);
         rem_s  = $signed(a) % $signed(b);
      end
   end

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hi_res = 32'd0;
      lo_res = 32'd0;
      case (op)
         MDU_MULT: begin
            hi_res = prod_s[63:32];
            lo_res = prod_s[31:0];
         end
         MDU_MULTU: begin
            hi_res = prod_u[63:32];
            lo_res = prod_u[31:0];
         end
         MDU_DIV: begin
            if (div_zero) begin
               hi_res = a;
               lo_res = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               hi_res = 32'd0;
               lo_res = 32'h8000_0000;
            end else begin
               hi_res = rem_s;
               lo_res = quot_s;
            end
         end
         MDU_DIVU: begin
            if (div_zero) begin
               hi_res = a;
               lo_res = 32'hFFFF_FFFF;
            end else begin
               hi_res = a % b;
               lo_res = a / b;
            end
         end
         default: begin
            hi_res = 32'd0;
            lo_res = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: holds HI/LO, models mult/div latency with busy/cnt,
// and serves mfhi/mflo reads to the E-stage writeback mux.
module mdu_e
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut_E
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      hi_pend_q, hi_pend_d;
   logic [31:0]      lo_pend_q, lo_pend_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      calc_hi;
   logic [31:0]      calc_lo;

   mdu_calc u_calc (
      .op     (MDUOp_E),
      .a      (A_E),
      .b      (B_E),
      .hi_res (calc_hi),
      .lo_res (calc_lo)
   );

   assign start = is_muldiv(MDUOp_E) && !busy_q;

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      hi_pend_d = hi_pend_q;
      lo_pend_d = lo_pend_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;

      // While busy every incoming op except mfhi/mflo is dropped.
      if (busy_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            hi_d   = hi_pend_q;
            lo_d   = lo_pend_q;
            busy_d = 1'b0;
         end
      end else if (start) begin
         hi_pend_d = calc_hi;
         lo_pend_d = calc_lo;
         busy_d    = 1'b1;
         cnt_d     = is_mult(MDUOp_E) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (MDUOp_E == MDU_MTHI) begin
         hi_d = A_E;
      end else if (MDUOp_E == MDU_MTLO) begin
         lo_d = A_E;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         hi_pend_q <= 32'd0;
         lo_pend_q <= 32'd0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         hi_pend_q <= hi_pend_d;
         lo_pend_q <= lo_pend_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

   always_comb begin
      MDUOut_E = 32'd0;
      if (MDUOp_E == MDU_MFHI)      MDUOut_E = hi_q;
      else if (MDUOp_E == MDU_MFLO) MDUOut_E = lo_q;
   end

endmodule
